// File: rtl/alu_pkg.sv
// Shared ALUop encoding, MIPS opcode/funct constants and the decoded-bundle
// type used by the issue stage and its decoder.
package alu_pkg;

  localparam int HAZ_SRC_N = 3;
  localparam int HAZ_W     = 6;  // {valid&we, dest[4:0]}

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [1:0] {SRC1_RS, SRC1_SHAMT, SRC1_ZERO} src1_sel_e;
  typedef enum logic [1:0] {SRC2_RT, SRC2_SEXT, SRC2_ZEXT, SRC2_ZERO} src2_sel_e;

  typedef struct packed {
    logic [3:0] alu_op;
    src1_sel_e  src1_sel;
    src2_sel_e  src2_sel;
    logic [4:0] dest;
    logic       gr_we;
    logic       ov_trap_en;
    logic       ri;
    logic       use_rs;
    logic       use_rt;
  } dec_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder for the MIPS integer ALU subset: instruction fields
// to ALUop, operand selects, destination and hazard source-use flags.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output dec_t       dec
);

  always_comb begin
    // Anything not matched below is issued as a reserved instruction.
    dec            = '0;
    dec.alu_op     = ALU_ADD;
    dec.src1_sel   = SRC1_ZERO;
    dec.src2_sel   = SRC2_ZERO;
    dec.ri         = 1'b1;

    if (opcode == OP_SPECIAL) begin
      dec.ri       = 1'b0;
      dec.gr_we    = 1'b1;
      dec.dest     = rd;
      dec.src1_sel = SRC1_RS;
      dec.src2_sel = SRC2_RT;
      dec.use_rs   = 1'b1;
      dec.use_rt   = 1'b1;
      case (funct)
        FN_ADD:  begin dec.alu_op = ALU_ADD; dec.ov_trap_en = 1'b1; end
        FN_ADDU: dec.alu_op = ALU_ADD;
        FN_SUB:  begin dec.alu_op = ALU_SUB; dec.ov_trap_en = 1'b1; end
        FN_SUBU: dec.alu_op = ALU_SUB;
        FN_SLT:  dec.alu_op = ALU_SLT;
        FN_SLTU: dec.alu_op = ALU_SLTU;
        FN_AND:  dec.alu_op = ALU_AND;
        FN_OR:   dec.alu_op = ALU_OR;
        FN_XOR:  dec.alu_op = ALU_XOR;
        FN_NOR:  dec.alu_op = ALU_NOR;
        FN_SLL, FN_SRL, FN_SRA: begin
          dec.alu_op   = (funct == FN_SLL) ? ALU_SLL :
                         (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
          dec.src1_sel = SRC1_SHAMT;
          dec.use_rs   = 1'b0;
        end
        default: begin
          dec          = '0;
          dec.alu_op   = ALU_ADD;
          dec.src1_sel = SRC1_ZERO;
          dec.src2_sel = SRC2_ZERO;
          dec.ri       = 1'b1;
        end
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          dec.ri       = 1'b0;
          dec.gr_we    = 1'b1;
          dec.dest     = rt;
          dec.src1_sel = SRC1_RS;
          dec.use_rs   = 1'b1;
          dec.src2_sel = SRC2_SEXT;
        end
        default: ;
      endcase
      case (opcode)
        OP_ADDI:  begin dec.alu_op = ALU_ADD; dec.ov_trap_en = 1'b1; end
        OP_ADDIU: dec.alu_op = ALU_ADD;
        OP_SLTI:  dec.alu_op = ALU_SLT;
        OP_SLTIU: dec.alu_op = ALU_SLTU;
        OP_ANDI:  begin dec.alu_op = ALU_AND; dec.src2_sel = SRC2_ZEXT; end
        OP_ORI:   begin dec.alu_op = ALU_OR;  dec.src2_sel = SRC2_ZEXT; end
        OP_XORI:  begin dec.alu_op = ALU_XOR; dec.src2_sel = SRC2_ZEXT; end
        OP_LUI: begin
          // The ALU forms imm<<16 itself, so A is forced to zero.
          dec.alu_op   = ALU_LUI;
          dec.src2_sel = SRC2_ZEXT;
          dec.src1_sel = SRC1_ZERO;
          dec.use_rs   = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: latches fetch output, reads the register file, stalls
// on RAW hazards against downstream stages and presents the ALU bundle.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fs_to_ds_valid,
  input  logic [31:0]           fs_inst,
  input  logic [31:0]           fs_pc,
  output logic                  ds_allowin,
  input  logic                  ds_flush,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic [REG_ADDR_W:0]   es_valid_we_dest,
  input  logic [REG_ADDR_W:0]   ms_valid_we_dest,
  input  logic [REG_ADDR_W:0]   ws_valid_we_dest,
  input  logic                  es_allowin,
  output logic                  ds_to_es_valid,
  output logic [3:0]            es_alu_op,
  output logic [DATA_WIDTH-1:0] es_alu_src1,
  output logic [DATA_WIDTH-1:0] es_alu_src2,
  output logic [REG_ADDR_W-1:0] es_dest,
  output logic                  es_gr_we,
  output logic                  es_ov_trap_en,
  output logic                  es_ri,
  output logic [31:0]           es_pc
);

  logic        ds_valid_reg;
  logic [31:0] inst_reg;
  logic [31:0] pc_reg;
  logic        ds_ready_go;
  logic        stall;
  dec_t        dec;

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [15:0]           imm;
  logic [4:0]            shamt;

  assign rs    = inst_reg[25:21];
  assign rt    = inst_reg[20:16];
  assign imm   = inst_reg[15:0];
  assign shamt = inst_reg[10:6];

  alu_issue_decode u_decode (
    .opcode (inst_reg[31:26]),
    .funct  (inst_reg[5:0]),
    .rt     (inst_reg[20:16]),
    .rd     (inst_reg[15:11]),
    .dec    (dec)
  );

  // RAW hazard: compare each used source against every in-flight writer.
  logic [REG_ADDR_W:0]  haz_bus [HAZ_SRC_N];
  logic [HAZ_SRC_N-1:0] hit_rs;
  logic [HAZ_SRC_N-1:0] hit_rt;

  assign haz_bus[0] = es_valid_we_dest;
  assign haz_bus[1] = ms_valid_we_dest;
  assign haz_bus[2] = ws_valid_we_dest;

  generate
    for (genvar gi = 0; gi < HAZ_SRC_N; gi++) begin : g_haz
      assign hit_rs[gi] = haz_bus[gi][REG_ADDR_W] && (rs != '0) &&
                          (haz_bus[gi][REG_ADDR_W-1:0] == rs);
      assign hit_rt[gi] = haz_bus[gi][REG_ADDR_W] && (rt != '0) &&
                          (haz_bus[gi][REG_ADDR_W-1:0] == rt);
    end
  endgenerate

  assign stall          = ds_valid_reg & ((dec.use_rs & (|hit_rs)) |
                                          (dec.use_rt & (|hit_rt)));
  assign ds_ready_go    = ~stall;
  assign ds_allowin     = ~ds_valid_reg | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_reg & ds_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_reg <= 1'b0;
      inst_reg     <= '0;
      pc_reg       <= '0;
    end else begin
      if (ds_flush) begin
        ds_valid_reg <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid_reg <= fs_to_ds_valid;
      end
      if (fs_to_ds_valid && ds_allowin && !ds_flush) begin
        inst_reg <= fs_inst;
        pc_reg   <= fs_pc;
      end
    end
  end

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  always_comb begin
    es_alu_src1 = '0;
    case (dec.src1_sel)
      SRC1_RS:    es_alu_src1 = rf_rdata1;
      SRC1_SHAMT: es_alu_src1 = {{(DATA_WIDTH-5){1'b0}}, shamt};
      default:    es_alu_src1 = '0;
    endcase
  end

  always_comb begin
    es_alu_src2 = '0;
    case (dec.src2_sel)
      SRC2_RT:   es_alu_src2 = rf_rdata2;
      SRC2_SEXT: es_alu_src2 = {{(DATA_WIDTH-16){imm[15]}}, imm};
      SRC2_ZEXT: es_alu_src2 = {{(DATA_WIDTH-16){1'b0}}, imm};
      default:   es_alu_src2 = '0;
    endcase
  end

  assign es_alu_op     = dec.alu_op;
  assign es_dest       = dec.dest;
  assign es_gr_we      = dec.gr_we;
  assign es_ov_trap_en = dec.ov_trap_en;
  assign es_ri         = dec.ri;
  assign es_pc         = pc_reg;

endmodule
